// File: rtl/ber_counter_if.sv
// ber_counter_if: signal bundle between the soft-rx control path and one
// ber_counter branch.
//   i_enable    soft rx enable; low freezes the counter
//   i_clear     synchronous soft clear (active-high)
//   i_valid     one strobe per received symbol
//   i_ref_bit   transmitted PRBS reference bit
//   i_rx_bit    detected received bit
//   o_accum_err accumulated bit errors since lock
//   o_accum_bit accumulated compared bits since lock
//   o_locked    reference-to-receive delay is locked
//   o_delay     current candidate (SEARCH) or locked delay
// Modports: master drives the strobes and reads results; slave is the counter.
interface ber_counter_if #(
  parameter int NBT_COUNT_BITS_ERR = 64,
  parameter int DELAY_W            = 9
);
  logic                          i_enable;
  logic                          i_clear;
  logic                          i_valid;
  logic                          i_ref_bit;
  logic                          i_rx_bit;
  logic [NBT_COUNT_BITS_ERR-1:0] o_accum_err;
  logic [NBT_COUNT_BITS_ERR-1:0] o_accum_bit;
  logic                          o_locked;
  logic [DELAY_W-1:0]            o_delay;

  modport master (
    output i_enable, i_clear, i_valid, i_ref_bit, i_rx_bit,
    input  o_accum_err, o_accum_bit, o_locked, o_delay
  );

  modport slave (
    input  i_enable, i_clear, i_valid, i_ref_bit, i_rx_bit,
    output o_accum_err, o_accum_bit, o_locked, o_delay
  );
endinterface

// File: rtl/ber_counter.sv
// ber_counter: per-branch bit-error-rate counter (one instance for I, one
// for Q). Searches for the delay between the transmitted PRBS reference and
// the detected receive stream, locks on it, then accumulates compared bits
// and bit errors in independently saturating counters.
// Ports:
//   clk      system clock
//   i_reset  asynchronous active-low reset
//   bus      ber_counter_if slave modport (enable/clear/valid/bits in,
//            accumulators/lock/delay out); all outputs are registered.
module ber_counter #(
  parameter int NBT_COUNT_BITS_ERR = 64,
  parameter int MAX_DELAY          = 512,
  parameter int SYNC_WINDOW        = 511,
  parameter int ERR_THRESHOLD      = 0,
  parameter int LOSS_THRESHOLD     = 128
) (
  input  logic          clk,
  input  logic          i_reset,
  ber_counter_if.slave  bus
);

  localparam int DW = $clog2(MAX_DELAY);
  localparam int CW = $clog2(SYNC_WINDOW + 1);
  localparam int NW = NBT_COUNT_BITS_ERR;

  typedef enum logic {SEARCH, LOCKED} state_t;

  state_t               state_q,   state_d;
  logic [MAX_DELAY-2:0] sr_q,      sr_d;
  logic [DW-1:0]        delay_q,   delay_d;
  logic [CW-1:0]        win_cnt_q, win_cnt_d;
  logic [CW-1:0]        win_err_q, win_err_d;
  logic [NW-1:0]        acc_err_q, acc_err_d;
  logic [NW-1:0]        acc_bit_q, acc_bit_d;

  logic                 accept;
  logic [MAX_DELAY-1:0] hist;
  logic                 mismatch;
  logic [31:0]          win_total;
  logic                 win_end;
  logic [DW-1:0]        next_delay;

  // Current reference bit sits at position 0, older bits above it, so the
  // candidate delay indexes the compare bit directly.
  assign accept     = bus.i_enable & bus.i_valid;
  assign hist       = {sr_q, bus.i_ref_bit};
  assign mismatch   = hist[delay_q] ^ bus.i_rx_bit;
  assign win_total  = 32'(win_err_q) + 32'(mismatch);
  assign win_end    = (win_cnt_q == CW'(SYNC_WINDOW - 1));
  assign next_delay = (delay_q == DW'(MAX_DELAY - 1)) ? '0 : delay_q + 1'b1;

  always_comb begin
    // NOTE: every next-state value defaults to its register first, so no
    // path through the branches below can leave a latch behind.
    state_d   = state_q;
    sr_d      = sr_q;
    delay_d   = delay_q;
    win_cnt_d = win_cnt_q;
    win_err_d = win_err_q;
    acc_err_d = acc_err_q;
    acc_bit_d = acc_bit_q;

    if (bus.i_clear) begin
      state_d   = SEARCH;
      sr_d      = '0;
      delay_d   = '0;
      win_cnt_d = '0;
      win_err_d = '0;
      acc_err_d = '0;
      acc_bit_d = '0;
    end else if (accept) begin
      sr_d      = {sr_q[MAX_DELAY-3:0], bus.i_ref_bit};
      win_cnt_d = win_cnt_q + 1'b1;
      win_err_d = win_err_q + CW'(mismatch);

      // Accumulate on the state held before this valid; the locking valid
      // itself is therefore never counted.
      if (state_q == LOCKED) begin
        if (acc_bit_q != '1)            acc_bit_d = acc_bit_q + 1'b1;
        if (mismatch && acc_err_q != '1) acc_err_d = acc_err_q + 1'b1;
      end

      if (win_end) begin
        win_cnt_d = '0;
        win_err_d = '0;
        case (state_q)
          SEARCH: begin
            if (win_total <= 32'(ERR_THRESHOLD)) begin
              state_d   = LOCKED;
              acc_err_d = '0;
              acc_bit_d = '0;
            end else begin
              delay_d = next_delay;
            end
          end
          LOCKED: begin
            if (win_total > 32'(LOSS_THRESHOLD)) begin
              state_d = SEARCH;
              delay_d = next_delay;
            end
          end
          default: state_d = SEARCH;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q   <= SEARCH;
      // NOTE: the reference history is a plain shift register, not a RAM,
      // and must start at zero, so it is reset with everything else.
      sr_q      <= '0;
      delay_q   <= '0;
      win_cnt_q <= '0;
      win_err_q <= '0;
      acc_err_q <= '0;
      acc_bit_q <= '0;
    end else begin
      // NOTE: non-blocking updates so every register samples pre-edge values.
      state_q   <= state_d;
      sr_q      <= sr_d;
      delay_q   <= delay_d;
      win_cnt_q <= win_cnt_d;
      win_err_q <= win_err_d;
      acc_err_q <= acc_err_d;
      acc_bit_q <= acc_bit_d;
    end
  end

  assign bus.o_accum_err = acc_err_q;
  assign bus.o_accum_bit = acc_bit_q;
  assign bus.o_locked    = (state_q == LOCKED);
  assign bus.o_delay     = delay_q;

endmodule

// File: doc/ber_counter.md
Name: ber_counter

Overview:
- Per-branch bit-error-rate counter feeding the register file's accumulated-error and accumulated-bit inputs.
- Instantiated once for I and once for Q.
- Compares detected receive bits against the transmitted PRBS reference bits.
- Searches automatically for the reference-to-receive delay, locks on it, then accumulates total compared bits and bit errors in saturating 64-bit counters.

Parameters:
- NBT_COUNT_BITS_ERR, 64, width of both accumulators
- MAX_DELAY, 512, number of candidate delays searched (0..MAX_DELAY-1); reference history depth
- SYNC_WINDOW, 511, valid bits per evaluation window
- ERR_THRESHOLD, 0, max window errors allowed to declare lock
- LOSS_THRESHOLD, 128, window errors above which lock is dropped

Ports:
- clk, input, 1, system clock
- i_reset, input, 1, reset, asynchronous, active-low
- i_enable, input, 1, from register file soft rx enable; low freezes all state
- i_clear, input, 1, synchronous soft clear, active-high
- i_valid, input, 1, one bit-pair strobe per symbol
- i_ref_bit, input, 1, transmitted PRBS bit
- i_rx_bit, input, 1, detected received bit
- o_accum_err, output, NBT_COUNT_BITS_ERR, accumulated bit errors since lock
- o_accum_bit, output, NBT_COUNT_BITS_ERR, accumulated compared bits since lock
- o_locked, output, 1, delay lock achieved
- o_delay, output, $clog2(MAX_DELAY), current candidate or locked delay

Behaviour:
- Reset (i_reset=0, async):
  - All outputs 0.
  - Reference history 0, window counters 0, state SEARCH.
- Priority (per clk edge, reset released): i_clear > (i_enable & i_valid) > hold.
  - i_clear=1: same values as reset, regardless of i_enable/i_valid.
  - i_enable=0 or i_valid=0: every register holds.
- Reference history sr[MAX_DELAY-2:0]:
  - On each accepted valid: sr <= {sr[MAX_DELAY-3:0], i_ref_bit}.
  - sr[0] is the previous valid's reference bit.
- Compare bit c = (o_delay==0) ? i_ref_bit : sr[o_delay-1].
  - mismatch m = c ^ i_rx_bit.
- Window logic (both states):
  - win_cnt counts accepted valids 1..SYNC_WINDOW.
  - win_err accumulates m.
  - On the valid where win_cnt reaches SYNC_WINDOW, the decision uses win_err including the current m; both counters then restart at 0.
- State SEARCH:
  - At window end, if total <= ERR_THRESHOLD: go to LOCKED; o_locked=1; o_delay unchanged; accumulators cleared to 0.
  - Otherwise o_delay <= o_delay+1, wrapping MAX_DELAY-1 -> 0; stay in SEARCH.
  - Accumulators hold during SEARCH.
- State LOCKED:
  - Each accepted valid: o_accum_bit += 1 and o_accum_err += m.
  - Each counter saturates independently at all-ones; no wrap.
  - At window end, if total > LOSS_THRESHOLD: go to SEARCH; o_locked=0; o_delay <= o_delay+1 with wrap; accumulators hold their last values.
- Latency: all outputs registered; one cycle after the accepted valid edge.
- Simultaneous events: a lock decision and an accumulate on the same valid use the new state from the next valid only. The locking valid itself is not counted.
- Reset or clear mid-window: partial window discarded.

Test Plan:
- Rx = ref delayed 5 valids, rx=0 for first 5 valids, no errors, thresholds default:
  - Delays 0..4 rejected.
  - o_locked rises 1 cycle after valid #3066 (6*511).
  - o_delay=5, accumulators 0.
- After the lock above, 1000 valids with rx flipped at valids 10, 200, 999:
  - o_accum_bit=1000, o_accum_err=3.
  - o_locked stays 1.
- NBT_COUNT_BITS_ERR=8, locked, 300 valids all inverted (LOSS_THRESHOLD=600 so lock is held):
  - o_accum_bit=255, o_accum_err=255, both held at 255.
- Locked, then rx forced to random uncorrelated bits for 511 valids:
  - o_locked falls after valid #511.
  - o_delay = locked value+1.
  - Accumulators frozen at pre-loss values.
- MAX_DELAY=8, rx uncorrelated:
  - o_delay steps 0..7, then 0 at window 9.
  - o_locked stays 0.
- Mid-count: i_enable=0 for 50 cycles with i_valid toggling -> no output change.
- i_clear pulse -> next cycle all outputs 0, state SEARCH.
- Async i_reset low between clk edges -> outputs 0 immediately.
